// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way request arbiter.
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef logic [N_REQ-1:0] req_vec_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   function automatic req_vec_t onehot(input idx_t idx);
      return req_vec_t'(1) << idx;
   endfunction

endpackage

// File: rtl/prio_pick8.sv
// Combinational picker: first set bit of i_vec at or above i_ptr, wrapping 7->0.
module prio_pick8
   import arb_pkg::*;
(
   input  logic [7:0] i_vec,
   input  logic [2:0] i_ptr,
   output logic       o_found,
   output logic [2:0] o_idx
);

   idx_t w_pos;

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_pos   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         w_pos = i_ptr + idx_t'(i);
         if (!o_found && i_vec[w_pos]) begin
            o_found = 1'b1;
            o_idx   = w_pos;
         end
      end
   end

endmodule

// File: rtl/req_arbiter8.sv
// Eight-way request arbiter: fixed or round-robin priority, grant held until
// release or hold timeout, registered one-hot grant plus binary index.
module req_arbiter8
   import arb_pkg::*;
#(
   parameter int          N        = N_REQ,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_req,
   input  logic       i_fixed_pri,
   output logic [7:0] o_gnt,
   output logic [2:0] o_gnt_idx,
   output logic       o_gnt_valid
);

   localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t HOLD_LAST = (MAX_HOLD == 0) ? '0 : cnt_t'(MAX_HOLD - 1);
   localparam idx_t LAST_IDX  = idx_t'(N - 1);

   arb_state_t r_state;
   req_vec_t   r_gnt;
   idx_t       r_gnt_idx;
   logic       r_gnt_valid;
   idx_t       r_ptr;
   cnt_t       r_hold_cnt;

   arb_state_t w_state_nxt;
   req_vec_t   w_gnt_nxt;
   idx_t       w_idx_nxt;
   logic       w_valid_nxt;
   idx_t       w_ptr_nxt;
   cnt_t       w_cnt_nxt;

   logic       w_fix_found, w_rr_found, w_to_found;
   idx_t       w_fix_idx, w_rr_idx, w_to_idx;
   logic       w_sel_found;
   idx_t       w_sel_idx;
   req_vec_t   w_masked;
   logic       w_new;
   idx_t       w_win_idx;

   // Timeout pick excludes the holder so the grant always moves on.
   assign w_masked = i_req & ~r_gnt;

   prio_pick8 u_pick_fix (
      .i_vec   (i_req),
      .i_ptr   ('0),
      .o_found (w_fix_found),
      .o_idx   (w_fix_idx)
   );

   prio_pick8 u_pick_rr (
      .i_vec   (i_req),
      .i_ptr   (r_ptr),
      .o_found (w_rr_found),
      .o_idx   (w_rr_idx)
   );

   prio_pick8 u_pick_to (
      .i_vec   (w_masked),
      .i_ptr   (r_ptr),
      .o_found (w_to_found),
      .o_idx   (w_to_idx)
   );

   assign w_sel_found = i_fixed_pri ? w_fix_found : w_rr_found;
   assign w_sel_idx   = i_fixed_pri ? w_fix_idx   : w_rr_idx;

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_idx_nxt   = r_gnt_idx;
      w_valid_nxt = r_gnt_valid;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_hold_cnt;
      w_new       = 1'b0;
      w_win_idx   = '0;

      case (r_state)
         ARB_IDLE: begin
            if (w_sel_found) begin
               w_new     = 1'b1;
               w_win_idx = w_sel_idx;
            end
         end
         ARB_GRANT: begin
            if (!i_req[r_gnt_idx]) begin
               if (w_sel_found) begin
                  w_new     = 1'b1;
                  w_win_idx = w_sel_idx;
               end else begin
                  w_state_nxt = ARB_IDLE;
                  w_gnt_nxt   = '0;
                  w_idx_nxt   = '0;
                  w_valid_nxt = 1'b0;
                  w_cnt_nxt   = '0;
               end
            end else if (MAX_HOLD != 0 && r_hold_cnt == HOLD_LAST && w_to_found) begin
               w_new     = 1'b1;
               w_win_idx = w_to_idx;
            end else if (MAX_HOLD != 0 && r_hold_cnt != HOLD_LAST) begin
               // Saturating at HOLD_LAST lets a lone holder keep the grant forever.
               w_cnt_nxt = r_hold_cnt + cnt_t'(1);
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase

      if (w_new) begin
         w_state_nxt = ARB_GRANT;
         w_gnt_nxt   = onehot(w_win_idx);
         w_idx_nxt   = w_win_idx;
         w_valid_nxt = 1'b1;
         w_ptr_nxt   = (w_win_idx == LAST_IDX) ? '0 : w_win_idx + idx_t'(1);
         w_cnt_nxt   = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ARB_IDLE;
         r_gnt       <= '0;
         r_gnt_idx   <= '0;
         r_gnt_valid <= 1'b0;
         r_ptr       <= '0;
         r_hold_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt       <= w_gnt_nxt;
         r_gnt_idx   <= w_idx_nxt;
         r_gnt_valid <= w_valid_nxt;
         r_ptr       <= w_ptr_nxt;
         r_hold_cnt  <= w_cnt_nxt;
      end
   end

   assign o_gnt       = r_gnt;
   assign o_gnt_idx   = r_gnt_idx;
   assign o_gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_req_arbiter8.sv
// Self-checking bench for req_arbiter8: two instances (MAX_HOLD=4 and 0) share stimulus.
module tb_req_arbiter8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       fixed;

   logic [7:0] g4, g0;
   logic [2:0] i4, i0;
   logic       v4, v0;

   int n_chk = 0;
   int n_err = 0;

   req_arbiter8 #(.N(8), .MAX_HOLD(4)) u_h4 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_fixed_pri (fixed),
      .o_gnt       (g4),
      .o_gnt_idx   (i4),
      .o_gnt_valid (v4)
   );

   req_arbiter8 #(.N(8), .MAX_HOLD(0)) u_h0 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_fixed_pri (fixed),
      .o_gnt       (g0),
      .o_gnt_idx   (i0),
      .o_gnt_valid (v0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got no summary expected summary");
      $fatal(1, "watchdog");
   end

   // Reference model: slot 0 models MAX_HOLD=4, slot 1 models MAX_HOLD=0.
   int m_busy [2];
   int m_hold [2];
   int m_ptr  [2];
   int m_age  [2];
   int MH     [2] = '{4, 0};

   function automatic int pick(input logic [7:0] v, input int start);
      for (int i = 0; i < 8; i++) begin
         int j;
         j = (start + i) % 8;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 0; m_hold[d] = 0; m_ptr[d] = 0; m_age[d] = 0;
      end
   endtask

   task automatic model_grant(input int d, input int k);
      m_busy[d] = 1;
      m_hold[d] = k;
      m_ptr[d]  = (k + 1) % 8;
      m_age[d]  = 0;
   endtask

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         int start;
         logic [7:0] others;
         start = fixed ? 0 : m_ptr[d];
         if (m_busy[d] == 0) begin
            if (req != 8'h00) model_grant(d, pick(req, start));
         end else begin
            m_age[d]++;
            others = req & ~(8'h01 << m_hold[d]);
            if (!req[m_hold[d]]) begin
               if (req != 8'h00) model_grant(d, pick(req, start));
               else m_busy[d] = 0;
            end else if (MH[d] != 0 && m_age[d] >= MH[d] && others != 8'h00) begin
               model_grant(d, pick(others, m_ptr[d]));
            end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [7:0] eg, ei, ev;
      for (int d = 0; d < 2; d++) begin
         ev = 8'(m_busy[d]);
         ei = (m_busy[d] != 0) ? 8'(m_hold[d]) : 8'h00;
         eg = (m_busy[d] != 0) ? (8'h01 << m_hold[d]) : 8'h00;
         if (d == 0) begin
            chk("h4.gnt", g4, eg); chk("h4.idx", 8'(i4), ei); chk("h4.valid", 8'(v4), ev);
         end else begin
            chk("h0.gnt", g0, eg); chk("h0.idx", 8'(i0), ei); chk("h0.valid", 8'(v0), ev);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      check_model();
   endtask

   task automatic expect_both(input string nm, input logic valid, input logic [2:0] idx);
      logic [7:0] eg;
      eg = valid ? (8'h01 << idx) : 8'h00;
      chk({nm, ".h4.valid"}, 8'(v4), 8'(valid));
      chk({nm, ".h4.idx"},   8'(i4), 8'(idx));
      chk({nm, ".h4.gnt"},   g4, eg);
      chk({nm, ".h0.valid"}, 8'(v0), 8'(valid));
      chk({nm, ".h0.idx"},   8'(i0), 8'(idx));
      chk({nm, ".h0.gnt"},   g0, eg);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      cycle();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [7:0] req;
      logic       fixed;
      logic       valid;
      logic [2:0] idx;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{8'hA4, 1'b1, 1'b1, 3'd2};
      tbl[1] = '{8'hA0, 1'b1, 1'b1, 3'd5};
      tbl[2] = '{8'h80, 1'b1, 1'b1, 3'd7};
      tbl[3] = '{8'h00, 1'b1, 1'b0, 3'd0};
      tbl[4] = '{8'h81, 1'b1, 1'b1, 3'd0};
      tbl[5] = '{8'h00, 1'b1, 1'b0, 3'd0};

      rst   = 1'b1;
      req   = 8'hFF;
      fixed = 1'b0;
      model_reset();

      // Reset holds outputs low regardless of requests, and idle stays idle.
      repeat (3) cycle();
      expect_both("rst_hold", 1'b0, 3'd0);
      req = 8'h00;
      rst = 1'b0;
      repeat (2) cycle();
      expect_both("idle", 1'b0, 3'd0);

      // Fixed priority with gapless handoff.
      for (int k = 0; k < 6; k++) begin
         req   = tbl[k].req;
         fixed = tbl[k].fixed;
         cycle();
         expect_both($sformatf("fixed%0d", k), tbl[k].valid, tbl[k].idx);
      end

      // Round-robin sweep, holder drops out each cycle.
      do_reset();
      fixed = 1'b0;
      req   = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         cycle();
         expect_both($sformatf("rr%0d", i), 1'b1, 3'(i % 8));
         req = 8'hFF & ~(8'h01 << (i % 8));
      end

      // Hold timeout on the MAX_HOLD=4 instance only.
      do_reset();
      fixed = 1'b1;
      req   = 8'h01;
      cycle();
      expect_both("to_grant", 1'b1, 3'd0);
      req = 8'h03;
      for (int j = 1; j < 4; j++) begin
         cycle();
         expect_both($sformatf("to_hold%0d", j), 1'b1, 3'd0);
      end
      cycle();
      chk("to_preempt.h4.idx", 8'(i4), 8'd1);
      chk("to_preempt.h0.idx", 8'(i0), 8'd0);
      req = 8'h01;
      cycle();
      expect_both("to_back0", 1'b1, 3'd0);
      repeat (20) cycle();
      expect_both("to_alone", 1'b1, 3'd0);
      req = 8'h03;
      cycle();
      chk("to_sat.h4.idx", 8'(i4), 8'd1);
      chk("to_sat.h0.idx", 8'(i0), 8'd0);

      // Mode flip mid-grant leaves the holder alone.
      do_reset();
      fixed = 1'b0;
      req   = 8'h08;
      cycle();
      expect_both("mode_rr", 1'b1, 3'd3);
      fixed = 1'b1;
      repeat (3) cycle();
      expect_both("mode_keep", 1'b1, 3'd3);
      req = 8'h81;
      cycle();
      expect_both("mode_fixed", 1'b1, 3'd0);

      // Asynchronous reset mid-grant restores the pointer.
      do_reset();
      fixed = 1'b0;
      req   = 8'h40;
      cycle();
      expect_both("arst_pre", 1'b1, 3'd6);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      expect_both("arst_now", 1'b0, 3'd0);
      req = 8'hC0;
      cycle();
      rst = 1'b0;
      cycle();
      expect_both("arst_post", 1'b1, 3'd6);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) fixed = ~fixed;
         case ($urandom_range(0, 9))
            0:       req = 8'($urandom);
            1:       req = 8'h00;
            2, 3, 4: req = req ^ (8'h01 << $urandom_range(0, 7));
            default: ;
         endcase
         if ($urandom_range(0, 199) == 0) begin
            #2;
            rst = 1'b1;
            #1;
            model_reset();
            check_model();
            cycle();
            rst = 1'b0;
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/req_arbiter8.md
# req_arbiter8

Eight-way request arbiter that shares one resource (one seven-segment/LED output path on the lab FPGA board) between eight switch- or logic-driven requesters. Each cycle it selects a winner among the asserted requests, using either fixed lowest-index priority or round-robin priority. It holds the grant until the winner releases its request or a hold timeout expires, and drives a one-hot grant plus its 3-bit index. It sits between the request sources and the shared output mux, which it steers with `gnt_idx`.

## Interface
- `N`, 8, number of requesters (fixed at 8 for this board; parameter exists only for package consistency).
- `MAX_HOLD`, 16, maximum consecutive cycles one requester keeps the grant while others wait; 0 disables the timeout.
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  8  request vector; bit i high = requester i wants the resource.
- `fixed_pri`  in  1  1 = fixed priority (bit 0 highest, bit 7 lowest); 0 = round-robin.
- `gnt`  out  8  one-hot grant; all zero when idle.
- `gnt_idx`  out  3  binary index of the granted requester; 0 when idle.
- `gnt_valid`  out  1  high while any grant is active (equals OR of `gnt`).

## Operation
- All outputs are registered. Reset values: `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, state=IDLE, round-robin pointer `ptr`=0, `hold_cnt`=0.
- FSM states:
  - IDLE: no grant. If `req`≠0, select a winner, go to GRANT, set `hold_cnt`=0. Otherwise stay in IDLE.
  - GRANT: the winner's `req` bit is high and the grant is held.
- Winner selection:
  - Fixed mode: lowest asserted index.
  - Round-robin mode: first asserted index scanning upward from `ptr`, wrapping 7→0.
- On every new grant to index k, `ptr` ← (k+1) mod 8, in both modes.
- In GRANT, at each edge, in priority order:
  1. `req[gnt_idx]`=0 (release): re-arbitrate among current `req`. If any bit is set, grant the new winner directly without an IDLE cycle. Otherwise go to IDLE.
  2. `MAX_HOLD`≠0, `hold_cnt`=`MAX_HOLD`-1, and another bit of `req` is set (timeout): preempt. Re-arbitrate with the current holder's bit masked out.
  3. Otherwise keep the grant and increment `hold_cnt`. The counter saturates at `MAX_HOLD`-1 when no other request is pending, so the holder keeps the grant indefinitely in that case.
- `hold_cnt` width is $clog2(`MAX_HOLD`+1); no wrap is permitted.
- `fixed_pri` is sampled only at arbitration edges. A change mid-grant does not disturb the current holder.
- `req` bits that drop without ever having been granted are simply ignored.

## Timing
- Latency: `req` asserted in cycle t (IDLE) → `gnt`/`gnt_idx`/`gnt_valid` valid from the edge ending cycle t, i.e. visible in cycle t+1.
- Release: holder drops `req` in cycle t → at the next edge, either the next winner is granted (visible in t+1) or outputs go to 0.
- Handoff never produces an overlap and never inserts a gap cycle when other requests are pending.
- Timeout: a holder granted at edge e, with a competitor pending, loses the grant at edge e+`MAX_HOLD`.
- Simultaneous release and timeout on the same edge: treated as a release; the holder's bit is already 0, so the result is identical.
- `rst` asserted mid-grant: all outputs drop to 0 immediately (asynchronously) and `ptr` returns to 0. The first arbitration after `rst` deasserts is a fresh IDLE decision.
- Outputs are stable for the whole cycle; there is no combinational path from `req` to the outputs.

## Structure
- Shared package `arb_pkg`:
  - `localparam N_REQ = 8`
  - `localparam IDX_W = 3`
  - `typedef logic [N_REQ-1:0] req_vec_t`
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t`
- Sub-module `prio_pick8`: combinational. Inputs are an 8-bit vector and a 3-bit start pointer. Outputs are a found flag and a 3-bit index of the first set bit at or above the pointer (wrapping).
  - Fixed mode calls it with pointer 0.
  - Round-robin mode calls it with `ptr`.
  - Timeout mode calls it with `ptr` and the holder's bit masked out.
- The top level holds the FSM, `ptr`, `hold_cnt`, and the output registers.

## Test plan
- **Reset / idle:** Hold `rst`=1 with `req`=8'hFF → `gnt`=0, `gnt_idx`=0, `gnt_valid`=0. Release `rst` with `req`=0 → outputs stay 0.
- **Fixed priority:** `fixed_pri`=1, `req`=8'b1010_0100 → next cycle `gnt`=8'b0000_0100, `gnt_idx`=2. Drop bit 2 → next cycle `gnt_idx`=5 with no gap. Drop bit 5 → `gnt_idx`=7.
- **Round-robin:** `fixed_pri`=0, `MAX_HOLD`=0, `req`=8'hFF, each holder releasing for one cycle after each grant → grant order 0,1,2,…,7,0. After the grant to 7, `ptr` wraps to 0.
- **Timeout:** `MAX_HOLD`=4, `fixed_pri`=1, `req`=8'h01 held, then `req`=8'h03 → bit 0 keeps the grant for exactly 4 cycles from its grant edge, then `gnt_idx`=1. With `req`=8'h01 alone for 20 cycles → bit 0 is never revoked.
- **Mode change mid-grant:** Grant held on index 3 under round-robin; flip `fixed_pri` to 1 → `gnt_idx` stays 3. On release with `req`=8'h81 → `gnt_idx`=0.
- **Async reset mid-grant:** Assert `rst` between edges while `gnt_idx`=6 → outputs go to 0 before the next edge. After deassert with `req`=8'hC0 in round-robin → `gnt_idx`=6, because `ptr` is back at 0.
